latch_output_monitor: RTL and testbench



---
 rtl/latch_output_monitor.sv | 246 ++++++++++++++++++++++++
 tb/tb_latch_output_monitor.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_output_monitor.sv
// Monitor for the gated SR/D latch outputs: synchronize q1/q2, check complementarity, debounce, count edges.
// Optional macro LATCH_MON_TIMESTAMP_EN stamps each debounced edge with a free-running cycle count.
module latch_output_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CYCLES    = 3,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q1_in,
    input  logic             q2_in,
    input  logic             clr,
    output logic             q_stable,
    output logic             q_valid,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_invalid,
    output logic [2:0]       state_o,
    output logic [31:0]      last_edge_ts
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int INV_W  = $clog2(ERR_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [INV_W-1:0]  INV_ONE  = INV_W'(1);
    localparam logic [INV_W-1:0]  INV_MAX  = INV_W'(ERR_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_LOW     = 3'd0,
        ST_RISING  = 3'd1,
        ST_HIGH    = 3'd2,
        ST_FALLING = 3'd3,
        ST_INVALID = 3'd4
    } state_t;

    // Synchronizer chains; reset values mirror the latch's own reset state (q1=0, q2=1).
    logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
    logic [SYNC_STAGES-1:0] sync2_q, sync2_d;
    logic                   s1, s2, valid;

    state_t            state_q, state_d;
    logic [STAB_W-1:0] stab_q, stab_d, stab_inc;
    logic [INV_W-1:0]  inv_q, inv_d, inv_inc;
    logic              q_stable_q, q_stable_d;
    logic              q_valid_q, q_valid_d;
    logic [CNT_W-1:0]  rise_q, rise_d;
    logic [CNT_W-1:0]  fall_q, fall_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              err_inv_q, err_inv_d;

    logic rise_ev, fall_ev, err_ev;
    logic start_edge, enter_inv;

    assign s1       = sync1_q[SYNC_STAGES-1];
    assign s2       = sync2_q[SYNC_STAGES-1];
    assign valid    = s1 ^ s2;
    assign stab_inc = stab_q + STAB_ONE;
    assign inv_inc  = inv_q + INV_ONE;

    always_comb begin
        sync1_d = {sync1_q[SYNC_STAGES-2:0], q1_in};
        sync2_d = {sync2_q[SYNC_STAGES-2:0], q2_in};
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
        state_d    = state_q;
        stab_d     = stab_q;
        inv_d      = inv_q;
        q_stable_d = q_stable_q;
        q_valid_d  = valid;
        rise_ev    = 1'b0;
        fall_ev    = 1'b0;
        err_ev     = 1'b0;
        start_edge = 1'b0;
        enter_inv  = 1'b0;

        case (state_q)
            ST_LOW: begin
                if (!valid)  enter_inv  = 1'b1;
                else if (s1) start_edge = 1'b1;
            end
            ST_HIGH: begin
                if (!valid)   enter_inv  = 1'b1;
                else if (!s1) start_edge = 1'b1;
            end
            ST_RISING: begin
                if (!valid) begin
                    enter_inv = 1'b1;
                end else if (s1) begin
                    if (stab_inc == STAB_MAX) begin
                        state_d    = ST_HIGH;
                        q_stable_d = 1'b1;
                        rise_ev    = 1'b1;
                        stab_d     = '0;
                    end else begin
                        stab_d = stab_inc;
                    end
                end else begin
                    state_d = ST_LOW;
                    stab_d  = '0;
                end
            end
            ST_FALLING: begin
                if (!valid) begin
                    enter_inv = 1'b1;
                end else if (!s1) begin
                    if (stab_inc == STAB_MAX) begin
                        state_d    = ST_LOW;
                        q_stable_d = 1'b0;
                        fall_ev    = 1'b1;
                        stab_d     = '0;
                    end else begin
                        stab_d = stab_inc;
                    end
                end else begin
                    state_d = ST_HIGH;
                    stab_d  = '0;
                end
            end
            ST_INVALID: begin
                if (!valid) begin
                    // inv_q parks at the threshold so the error fires once per episode
                    if (inv_q != INV_MAX) begin
                        inv_d  = inv_inc;
                        err_ev = (inv_inc == INV_MAX);
                    end
                end else begin
                    inv_d = '0;
                    if (s1 == q_stable_q) state_d = q_stable_q ? ST_HIGH : ST_LOW;
                    else                  start_edge = 1'b1;
                end
            end
            default: state_d = ST_LOW;
        endcase

        // A new differing value either opens a debounce window or, with a one-cycle window, is taken at once.
        if (start_edge) begin
            if (STAB_MAX == STAB_ONE) begin
                state_d    = s1 ? ST_HIGH : ST_LOW;
                q_stable_d = s1;
                rise_ev    = s1;
                fall_ev    = !s1;
                stab_d     = '0;
            end else begin
                state_d = s1 ? ST_RISING : ST_FALLING;
                stab_d  = STAB_ONE;
            end
        end

        if (enter_inv) begin
            state_d = ST_INVALID;
            inv_d   = INV_ONE;
            stab_d  = '0;
            err_ev  = (INV_ONE == INV_MAX);
        end
    end

    // Status counters: clr dominates any same-cycle increment or error set.
    always_comb begin
        rise_d    = rise_q;
        fall_d    = fall_q;
        err_d     = err_q;
        err_inv_d = err_inv_q;
        if (clr) begin
            rise_d    = '0;
            fall_d    = '0;
            err_d     = '0;
            err_inv_d = 1'b0;
        end else begin
            if (rise_ev && rise_q != CNT_MAX) rise_d = rise_q + CNT_ONE;
            if (fall_ev && fall_q != CNT_MAX) fall_d = fall_q + CNT_ONE;
            if (err_ev  && err_q  != CNT_MAX) err_d  = err_q + CNT_ONE;
            if (err_ev)                       err_inv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '1;
            state_q    <= ST_LOW;
            stab_q     <= '0;
            inv_q      <= '0;
            q_stable_q <= 1'b0;
            q_valid_q  <= 1'b1;
            rise_q     <= '0;
            fall_q     <= '0;
            err_q      <= '0;
            err_inv_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            stab_q     <= stab_d;
            inv_q      <= inv_d;
            q_stable_q <= q_stable_d;
            q_valid_q  <= q_valid_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            err_q      <= err_d;
            err_inv_q  <= err_inv_d;
        end
    end

`ifdef LATCH_MON_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] last_ts_q, last_ts_d;

    // Stamp on every accepted edge, even when the edge counter is saturated or being cleared.
    always_comb begin
        ts_d      = ts_q + 32'd1;
        last_ts_d = (rise_ev || fall_ev) ? ts_q : last_ts_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q      <= '0;
            last_ts_q <= '0;
        end else begin
            ts_q      <= ts_d;
            last_ts_q <= last_ts_d;
        end
    end

    assign last_edge_ts = last_ts_q;
`else
    assign last_edge_ts = 32'd0;
`endif

    assign q_stable    = q_stable_q;
    assign q_valid     = q_valid_q;
    assign rise_cnt    = rise_q;
    assign fall_cnt    = fall_q;
    assign err_cnt     = err_q;
    assign err_invalid = err_inv_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_latch_output_monitor.sv
// Bench for latch_output_monitor: directed vector table, hand sequences, and a randomized run against a
// window-based reference model. Instance a uses default parameters; instance b uses CNT_W=2, STABLE=1, ERR=1.
`timescale 1ns/1ps
module tb_latch_output_monitor;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic q1_in = 1'b0;
    logic q2_in = 1'b1;
    logic clr = 1'b0;
    logic clr2 = 1'b0;

    logic        qs_a, qv_a, einv_a;
    logic [15:0] rise_a, fall_a, err_a;
    logic [2:0]  st_a;
    logic [31:0] ts_a;

    logic        qs_b, qv_b, einv_b;
    logic [1:0]  rise_b, fall_b, err_b;
    logic [2:0]  st_b;
    logic [31:0] ts_b;

    always #5 clk = ~clk;

    latch_output_monitor #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4), .ERR_CYCLES(3), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .q1_in(q1_in), .q2_in(q2_in), .clr(clr),
        .q_stable(qs_a), .q_valid(qv_a), .rise_cnt(rise_a), .fall_cnt(fall_a), .err_cnt(err_a),
        .err_invalid(einv_a), .state_o(st_a), .last_edge_ts(ts_a)
    );

    latch_output_monitor #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1), .ERR_CYCLES(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .q1_in(q1_in), .q2_in(q2_in), .clr(clr2),
        .q_stable(qs_b), .q_valid(qv_b), .rise_cnt(rise_b), .fall_cnt(fall_b), .err_cnt(err_b),
        .err_invalid(einv_b), .state_o(st_b), .last_edge_ts(ts_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A debounced edge happens when the last STABLE synchronized samples are all valid and all differ
    // from the current debounced value; an error episode is declared when the invalid run hits ERR.
    typedef struct packed { logic q1; logic q2; } pair_t;

    pair_t       pipe[$];
    pair_t       hist[$];
    logic        m_qs[2];
    logic        m_qv;
    int          inv_run[2];
    int          m_rise[2], m_fall[2], m_err[2];
    logic        m_einv[2];
    logic [2:0]  m_st[2];
    logic [31:0] m_ts[2];
    logic [31:0] cyc;

    function automatic int stab_of(input int i); return (i == 0) ? 4 : 1; endfunction
    function automatic int errc_of(input int i); return (i == 0) ? 3 : 1; endfunction
    function automatic int max_of(input int i);  return (i == 0) ? 65535 : 3; endfunction

    function automatic logic window_flip(input int i);
        int s;
        s = stab_of(i);
        if (hist.size() < s) return 1'b0;
        for (int k = hist.size() - s; k < hist.size(); k++)
            if (hist[k].q1 == hist[k].q2 || hist[k].q1 == m_qs[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        pipe.delete();
        hist.delete();
        for (int k = 0; k < SYNC; k++) pipe.push_back(pair_t'(2'b01));
        m_qv = 1'b1;
        cyc  = 32'd0;
        for (int i = 0; i < 2; i++) begin
            m_qs[i] = 1'b0; inv_run[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_err[i] = 0;
            m_einv[i] = 1'b0; m_st[i] = 3'd0; m_ts[i] = 32'd0;
        end
    endtask

    task automatic model_edge();
        pair_t smp;
        logic  ok, rev, fev, eev, c;
        smp = pipe.pop_front();
        pipe.push_back(pair_t'({q1_in, q2_in}));
        hist.push_back(smp);
        if (hist.size() > 8) void'(hist.pop_front());
        ok   = (smp.q1 != smp.q2);
        m_qv = ok;
        for (int i = 0; i < 2; i++) begin
            c = (i == 0) ? clr : clr2;
            inv_run[i] = ok ? 0 : inv_run[i] + 1;
            eev = (inv_run[i] == errc_of(i));
            rev = 1'b0;
            fev = 1'b0;
            if (ok && window_flip(i)) begin
                m_qs[i] = ~m_qs[i];
                rev = m_qs[i];
                fev = ~m_qs[i];
            end
            if (!ok)                    m_st[i] = 3'd4;
            else if (smp.q1 == m_qs[i]) m_st[i] = m_qs[i] ? 3'd2 : 3'd0;
            else                        m_st[i] = m_qs[i] ? 3'd3 : 3'd1;
            if (c) begin
                m_rise[i] = 0; m_fall[i] = 0; m_err[i] = 0; m_einv[i] = 1'b0;
            end else begin
                if (rev && m_rise[i] < max_of(i)) m_rise[i]++;
                if (fev && m_fall[i] < max_of(i)) m_fall[i]++;
                if (eev && m_err[i]  < max_of(i)) m_err[i]++;
                if (eev) m_einv[i] = 1'b1;
            end
            if (rev || fev) m_ts[i] = cyc;
        end
        cyc = cyc + 32'd1;
    endtask

    function automatic logic [31:0] exp_ts(input int i);
`ifdef LATCH_MON_TIMESTAMP_EN
        return m_ts[i];
`else
        return (i < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic compare_model();
        check("model a q_stable", {31'd0, qs_a}, {31'd0, m_qs[0]});
        check("model a q_valid", {31'd0, qv_a}, {31'd0, m_qv});
        check("model a state", {29'd0, st_a}, {29'd0, m_st[0]});
        check("model a rise_cnt", {16'd0, rise_a}, m_rise[0]);
        check("model a fall_cnt", {16'd0, fall_a}, m_fall[0]);
        check("model a err_cnt", {16'd0, err_a}, m_err[0]);
        check("model a err_invalid", {31'd0, einv_a}, {31'd0, m_einv[0]});
        check("model a last_edge_ts", ts_a, exp_ts(0));
        check("model b q_stable", {31'd0, qs_b}, {31'd0, m_qs[1]});
        check("model b state", {29'd0, st_b}, {29'd0, m_st[1]});
        check("model b rise_cnt", {30'd0, rise_b}, m_rise[1]);
        check("model b fall_cnt", {30'd0, fall_b}, m_fall[1]);
        check("model b err_cnt", {30'd0, err_b}, m_err[1]);
        check("model b err_invalid", {31'd0, einv_b}, {31'd0, m_einv[1]});
        check("model b last_edge_ts", ts_b, exp_ts(1));
    endtask

    // Inputs change on the falling edge; outputs are compared on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        q1_in = a;
        q2_in = b;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " a q_stable"}, {31'd0, qs_a}, 32'd0);
        check({tag, " a q_valid"}, {31'd0, qv_a}, 32'd1);
        check({tag, " a state"}, {29'd0, st_a}, 32'd0);
        check({tag, " a rise_cnt"}, {16'd0, rise_a}, 32'd0);
        check({tag, " a fall_cnt"}, {16'd0, fall_a}, 32'd0);
        check({tag, " a err_cnt"}, {16'd0, err_a}, 32'd0);
        check({tag, " a err_invalid"}, {31'd0, einv_a}, 32'd0);
        check({tag, " a last_edge_ts"}, ts_a, 32'd0);
        check({tag, " b state"}, {29'd0, st_b}, 32'd0);
        check({tag, " b q_stable"}, {31'd0, qs_b}, 32'd0);
        check({tag, " b rise_cnt"}, {30'd0, rise_b}, 32'd0);
        check({tag, " b err_invalid"}, {31'd0, einv_b}, 32'd0);
    endtask

    // ---------------- directed vector table (instance a) ----------------
    typedef struct {
        logic       q1, q2;
        logic [2:0] st;
        logic       qs, qv;
        int         rise, fall, err;
        logic       einv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic q1, input logic q2, input logic [2:0] st, input logic qs, input logic qv,
                       input int rise, input int fall, input int err, input logic einv);
        vec_t v;
        v.q1 = q1; v.q2 = q2; v.st = st; v.qs = qs; v.qv = qv;
        v.rise = rise; v.fall = fall; v.err = err; v.einv = einv;
        tbl.push_back(v);
    endtask

    initial begin
        int hold;

        // Rise and hold: q_stable rises six cycles after the input change.
        add(1,0, 0,0,1, 0,0,0,0); add(1,0, 0,0,1, 0,0,0,0); add(1,0, 1,0,1, 0,0,0,0);
        add(1,0, 1,0,1, 0,0,0,0); add(1,0, 1,0,1, 0,0,0,0); add(1,0, 2,1,1, 1,0,0,0);
        add(1,0, 2,1,1, 1,0,0,0); add(1,0, 2,1,1, 1,0,0,0);
        // Two-cycle low glitch from HIGH is discarded.
        add(0,1, 2,1,1, 1,0,0,0); add(0,1, 2,1,1, 1,0,0,0); add(1,0, 3,1,1, 1,0,0,0);
        add(1,0, 3,1,1, 1,0,0,0); add(1,0, 2,1,1, 1,0,0,0); add(1,0, 2,1,1, 1,0,0,0);
        // Two-cycle invalid episode: no error.
        add(1,1, 2,1,1, 1,0,0,0); add(1,1, 2,1,1, 1,0,0,0); add(1,0, 4,1,0, 1,0,0,0);
        add(1,0, 4,1,0, 1,0,0,0); add(1,0, 2,1,1, 1,0,0,0); add(1,0, 2,1,1, 1,0,0,0);
        // Five-cycle invalid episode: one error, q_stable unchanged.
        add(1,1, 2,1,1, 1,0,0,0); add(1,1, 2,1,1, 1,0,0,0); add(1,1, 4,1,0, 1,0,0,0);
        add(1,1, 4,1,0, 1,0,0,0); add(1,1, 4,1,0, 1,0,1,1); add(1,0, 4,1,0, 1,0,1,1);
        add(1,0, 4,1,0, 1,0,1,1); add(1,0, 2,1,1, 1,0,1,1); add(1,0, 2,1,1, 1,0,1,1);

        // Reset and idle.
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("in reset");
        reset = 1'b1;
        drive(1'b0, 1'b1, 20);
        check_reset_values("idle");

        foreach (tbl[r]) begin
            q1_in = tbl[r].q1;
            q2_in = tbl[r].q2;
            tick();
            check($sformatf("row%0d state", r), {29'd0, st_a}, {29'd0, tbl[r].st});
            check($sformatf("row%0d q_stable", r), {31'd0, qs_a}, {31'd0, tbl[r].qs});
            check($sformatf("row%0d q_valid", r), {31'd0, qv_a}, {31'd0, tbl[r].qv});
            check($sformatf("row%0d rise_cnt", r), {16'd0, rise_a}, tbl[r].rise);
            check($sformatf("row%0d fall_cnt", r), {16'd0, fall_a}, tbl[r].fall);
            check($sformatf("row%0d err_cnt", r), {16'd0, err_a}, tbl[r].err);
            check($sformatf("row%0d err_invalid", r), {31'd0, einv_a}, {31'd0, tbl[r].einv});
        end
        // Instance b takes every edge and declares an error on the first invalid cycle.
        check("b rise after table", {30'd0, rise_b}, 32'd2);
        check("b fall after table", {30'd0, fall_b}, 32'd1);
        check("b err after table", {30'd0, err_b}, 32'd2);

        // Fall, then clr on the very cycle the next rise is counted.
        drive(1'b0, 1'b1, 6);
        check("fall q_stable", {31'd0, qs_a}, 32'd0);
        check("fall fall_cnt", {16'd0, fall_a}, 32'd1);
        drive(1'b1, 1'b0, 5);
        check("pre-clr state", {29'd0, st_a}, 32'd1);
        check("pre-clr rise_cnt", {16'd0, rise_a}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr rise_cnt", {16'd0, rise_a}, 32'd0);
        check("clr fall_cnt", {16'd0, fall_a}, 32'd0);
        check("clr err_cnt", {16'd0, err_a}, 32'd0);
        check("clr err_invalid", {31'd0, einv_a}, 32'd0);
        check("clr q_stable kept", {31'd0, qs_a}, 32'd1);
        check("clr state HIGH", {29'd0, st_a}, 32'd2);

        // Five debounced rises: instance b saturates at 3.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 6);
            drive(1'b1, 1'b0, 6);
        end
        check("toggle a rise_cnt", {16'd0, rise_a}, 32'd5);
        check("toggle a fall_cnt", {16'd0, fall_a}, 32'd5);
        check("sat b rise_cnt", {30'd0, rise_b}, 32'd3);
        check("sat b fall_cnt", {30'd0, fall_b}, 32'd3);

        // Asynchronous reset in the middle of a RISING window.
        drive(1'b0, 1'b1, 6);
        drive(1'b1, 1'b0, 3);
        check("mid-rise state", {29'd0, st_a}, 32'd1);
        #2;
        reset = 1'b0;
        q1_in = 1'b0;
        q2_in = 1'b1;
        #1;
        check_reset_values("async reset");
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Randomized run against the reference model.
        hold = 0;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 8) begin
                    q1_in = 1'($urandom_range(0, 1));
                    q2_in = ~q1_in;
                end else begin
                    q1_in = 1'($urandom_range(0, 1));
                    q2_in = q1_in;
                end
                hold = $urandom_range(1, 8);
            end
            hold--;
            clr  = ($urandom_range(0, 31) == 0);
            clr2 = ($urandom_range(0, 63) == 0);
            tick();
        end
        clr  = 1'b0;
        clr2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
